// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_pkg
//  Description : Shared types and constants for the instruction-fetch stage:
//                machine word size, instruction width, loader byte count and
//                the boot-loader state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

    // Machine word (address / PC) width shared with the control unit.
    localparam int WORD_SIZE           = 8;
    // Program word width and the number of loader bytes that build one word.
    localparam int INSTR_W             = 40;
    localparam int LOAD_BYTES_PER_WORD = 5;

    typedef enum logic [1:0] {
        LIDLE = 2'd0,
        LASM  = 2'd1,
        LWR   = 2'd2
    } LOADER_STATE_T;

endpackage : fetch_unit_pkg
`default_nettype wire

// File: rtl/fetch_unit_prog_mem.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_prog_mem
//  Description : Program store. DEPTH x WIDTH array with one synchronous
//                write port and one synchronous read port. No reset, so the
//                contents survive core resets and a plain RAM is inferred.
//  Ports       : clk      - clock
//                i_we     - write enable
//                i_waddr  - write address
//                i_wdata  - write data
//                i_raddr  - read address (sampled every cycle)
//                o_rdata  - registered read data
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit_prog_mem #(
    parameter int DEPTH  = 256,
    parameter int WIDTH  = 40,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_rdata <= r_mem[i_raddr];
    end

endmodule : fetch_unit_prog_mem
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction-fetch and program-store stage. Owns the PC, the
//                program memory and the instruction register, and contains a
//                byte-serial boot loader that fills program memory while the
//                core is held.
//  Ports       : clk, reset    - clock, synchronous active-high reset
//                next_pc       - next PC from the control unit
//                pc            - current program counter
//                instruction   - program word at pc
//                instr_valid   - instruction corresponds to pc
//                load_en       - boot-load mode request (level)
//                load_byte     - loader data, MS byte of each word first
//                load_valid    - load_byte offered this cycle
//                load_ready    - load_byte accepted this cycle
//                core_hold     - ORed into the control unit's reset
//                load_words    - words committed in current/last load
//                load_err      - sticky overflow / partial-word flag
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    // Must equal 2**WORD_SIZE.
    parameter int PROG_DEPTH = 256,
    parameter int INSTR_W    = fetch_unit_pkg::INSTR_W
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [fetch_unit_pkg::WORD_SIZE-1:0] next_pc,
    output logic [fetch_unit_pkg::WORD_SIZE-1:0] pc,
    output logic [INSTR_W-1:0]                 instruction,
    output logic                               instr_valid,
    input  logic                               load_en,
    input  logic [7:0]                         load_byte,
    input  logic                               load_valid,
    output logic                               load_ready,
    output logic                               core_hold,
    output logic [fetch_unit_pkg::WORD_SIZE-1:0] load_words,
    output logic                               load_err
);

    import fetch_unit_pkg::*;

    localparam logic [2:0]           c_LAST_BYTE = 3'(LOAD_BYTES_PER_WORD - 1);
    localparam logic [WORD_SIZE-1:0] c_LAST_WORD = WORD_SIZE'(PROG_DEPTH - 1);

    LOADER_STATE_T          r_state;
    logic [2:0]             r_byte_cnt;
    logic [INSTR_W-1:0]     r_asm;
    logic [WORD_SIZE-1:0]   r_waddr;
    logic [WORD_SIZE-1:0]   r_words;
    logic                   r_full;      // last memory word has been written
    logic                   r_err;

    logic                   w_accept;
    logic                   w_we;
    logic [WORD_SIZE-1:0]   w_raddr;

    assign load_ready = (r_state == LASM) && load_en;
    assign w_accept   = load_ready && load_valid;
    assign core_hold  = (r_state != LIDLE) || load_en;
    assign load_words = r_words;
    assign load_err   = r_err;

    // A complete word caught in LWR by reset is discarded like a partial one.
    assign w_we = (r_state == LWR) && !r_full && !reset;

    // Held or in reset the read port points at word 0, so the core always
    // restarts on the first program word.
    assign w_raddr = (reset || core_hold) ? '0 : next_pc;

    // ------------------------------------------------------------------
    // Boot loader
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= LIDLE;
            r_byte_cnt <= '0;
            r_waddr    <= '0;
            r_words    <= '0;
            r_full     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                LIDLE: begin
                    if (load_en) begin
                        r_state    <= LASM;
                        r_byte_cnt <= '0;
                        r_waddr    <= '0;
                        r_words    <= '0;
                        r_full     <= 1'b0;
                        r_err      <= 1'b0;
                    end
                end

                LASM: begin
                    if (!load_en) begin
                        // Leaving mid-word drops the partial word.
                        r_state    <= LIDLE;
                        r_byte_cnt <= '0;
                        if (r_byte_cnt != '0) begin
                            r_err <= 1'b1;
                        end
                    end else if (w_accept) begin
                        r_asm <= {r_asm[INSTR_W-9:0], load_byte};
                        if (r_byte_cnt == c_LAST_BYTE) begin
                            r_byte_cnt <= '0;
                            r_state    <= LWR;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 3'd1;
                        end
                    end
                end

                LWR: begin
                    if (r_full) begin
                        // Memory already full: the word is dropped.
                        r_err <= 1'b1;
                    end else if (r_words == c_LAST_WORD) begin
                        // Final word committed; address and count saturate
                        // because the count cannot represent PROG_DEPTH.
                        r_full <= 1'b1;
                    end else begin
                        r_waddr <= r_waddr + 1'b1;
                        r_words <= r_words + 1'b1;
                    end
                    r_state <= load_en ? LASM : LIDLE;
                end

                default: begin
                    r_state <= LIDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Fetch register: pc follows next_pc, matched by the synchronous read.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset || core_hold) begin
            pc          <= '0;
            instr_valid <= 1'b0;
        end else begin
            pc          <= next_pc;
            instr_valid <= 1'b1;
        end
    end

    fetch_unit_prog_mem #(
        .DEPTH  (PROG_DEPTH),
        .WIDTH  (INSTR_W),
        .ADDR_W (WORD_SIZE)
    ) u_prog_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_waddr),
        .i_wdata (r_asm),
        .i_raddr (w_raddr),
        .o_rdata (instruction)
    );

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit. Expected program words
//                are queued as loader stimulus is driven and popped when the
//                fetch path reads them back.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  next_pc;
    logic [7:0]  pc;
    logic [39:0] instruction;
    logic        instr_valid;
    logic        load_en;
    logic [7:0]  load_byte;
    logic        load_valid;
    logic        load_ready;
    logic        core_hold;
    logic [7:0]  load_words;
    logic        load_err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0]  addr;
        logic [39:0] data;
    } exp_t;

    exp_t sb[$];

    fetch_unit #(
        .PROG_DEPTH (256),
        .INSTR_W    (40)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .next_pc     (next_pc),
        .pc          (pc),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .load_en     (load_en),
        .load_byte   (load_byte),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .core_hold   (core_hold),
        .load_words  (load_words),
        .load_err    (load_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [39:0] word_of(input int i);
        logic [7:0] lo;
        lo = i[7:0];
        if (i >= 256) return 40'hDE_ADBE_EF00;
        return {lo, 8'h5A, 16'(i * 3 + 7), ~lo};
    endfunction

    function automatic exp_t mk(input logic [7:0] a, input logic [39:0] d);
        exp_t e;
        e.addr = a;
        e.data = d;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int   n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        load_byte  = b;
        load_valid = 1'b1;
        while (!acc && n < 20) begin
            @(negedge clk);
            acc = load_ready;
            step();
            n++;
        end
        load_valid = 1'b0;
        n_checks++;
        if (!acc) begin
            n_fail++;
            $display("FAIL send_byte: byte %h never accepted, load_ready=0 required 1", b);
        end
    endtask

    task automatic send_word(input logic [39:0] w);
        for (int k = 4; k >= 0; k--) begin
            send_byte(w[k*8 +: 8]);
        end
    endtask

    task automatic verify_sb();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            next_pc = e.addr;
            step();
            n_checks++;
            if (pc !== e.addr) begin
                n_fail++;
                $display("FAIL fetch_pc: pc=%h required %h", pc, e.addr);
            end
            n_checks++;
            if (instruction !== e.data) begin
                n_fail++;
                $display("FAIL fetch_instr @%h: instruction=%h required %h", e.addr, instruction, e.data);
            end
            n_checks++;
            if (instr_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL fetch_valid @%h: instr_valid=%b required 1", e.addr, instr_valid);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; load_en = 1'b1; load_valid = 1'b0; load_byte = 8'h00; next_pc = 8'h00;
        step();
        step();
        n_checks++;
        if (core_hold !== 1'b1) begin n_fail++; $display("FAIL rst_hold_en: core_hold=%b required 1", core_hold); end
        n_checks++;
        if (load_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: load_ready=%b required 0", load_ready); end
        n_checks++;
        if (pc !== 8'h00) begin n_fail++; $display("FAIL rst_pc: pc=%h required 00", pc); end
        n_checks++;
        if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: instr_valid=%b required 0", instr_valid); end
        n_checks++;
        if (load_words !== 8'h00) begin n_fail++; $display("FAIL rst_words: load_words=%h required 00", load_words); end
        n_checks++;
        if (load_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: load_err=%b required 0", load_err); end
        load_en = 1'b0;
        step();
        n_checks++;
        if (core_hold !== 1'b0) begin n_fail++; $display("FAIL rst_hold: core_hold=%b required 0", core_hold); end
        reset = 1'b0;
        step();
        n_checks++;
        if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL rst_valid_rise: instr_valid=%b required 1", instr_valid); end
    endtask

    task automatic test_load_basic();
        load_en = 1'b1;
        step();
        send_word(40'h01_0203_0405); sb.push_back(mk(8'h00, 40'h01_0203_0405));
        send_word(40'hAA_BBCC_DDEE); sb.push_back(mk(8'h01, 40'hAA_BBCC_DDEE));
        load_en = 1'b0;
        next_pc = 8'h00;
        step();
        n_checks++;
        if (core_hold !== 1'b0) begin n_fail++; $display("FAIL load_hold: core_hold=%b required 0", core_hold); end
        n_checks++;
        if (load_words !== 8'd2) begin n_fail++; $display("FAIL load_words: load_words=%0d required 2", load_words); end
        n_checks++;
        if (load_err !== 1'b0) begin n_fail++; $display("FAIL load_err: load_err=%b required 0", load_err); end
        n_checks++;
        if (instruction !== 40'h01_0203_0405) begin
            n_fail++; $display("FAIL load_instr0: instruction=%h required 0102030405", instruction);
        end
        verify_sb();
    endtask

    task automatic test_partial();
        load_en = 1'b1;
        step();
        send_word(40'h11_1213_1415); sb.push_back(mk(8'h00, 40'h11_1213_1415));
        send_byte(8'h21);
        send_byte(8'h22);
        sb.push_back(mk(8'h01, 40'hAA_BBCC_DDEE));
        load_en = 1'b0;
        step();
        n_checks++;
        if (load_words !== 8'd1) begin n_fail++; $display("FAIL part_words: load_words=%0d required 1", load_words); end
        n_checks++;
        if (load_err !== 1'b1) begin n_fail++; $display("FAIL part_err: load_err=%b required 1", load_err); end
        n_checks++;
        if (core_hold !== 1'b0) begin n_fail++; $display("FAIL part_hold: core_hold=%b required 0", core_hold); end
        verify_sb();
        n_checks++;
        if (load_err !== 1'b1) begin n_fail++; $display("FAIL part_err_sticky: load_err=%b required 1", load_err); end
    endtask

    task automatic test_reset_preload();
        reset = 1'b1; next_pc = 8'h05;
        step();
        n_checks++;
        if (pc !== 8'h00) begin n_fail++; $display("FAIL pre_pc: pc=%h required 00", pc); end
        n_checks++;
        if (instruction !== 40'h11_1213_1415) begin
            n_fail++; $display("FAIL pre_instr: instruction=%h required 1112131415", instruction);
        end
        n_checks++;
        if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL pre_valid0: instr_valid=%b required 0", instr_valid); end
        n_checks++;
        if (load_err !== 1'b0) begin n_fail++; $display("FAIL pre_err: load_err=%b required 0", load_err); end
        reset = 1'b0;
        next_pc = 8'h00;
        step();
        n_checks++;
        if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL pre_valid1: instr_valid=%b required 1", instr_valid); end
    endtask

    // Continuous load_valid over a full memory plus one extra word.
    task automatic test_back_to_back();
        int          idx;
        int          phase;
        int          cyc;
        logic [39:0] w;
        logic        exp_rdy;
        idx = 0; phase = 0; cyc = 0;
        load_en = 1'b1;
        step();
        load_valid = 1'b1;
        while (idx < 257 * 5 && cyc < 4000) begin
            w = word_of(idx / 5);
            load_byte = w[(4 - idx % 5) * 8 +: 8];
            @(negedge clk);
            exp_rdy = (phase != 5);
            n_checks++;
            if (load_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL b2b_ready cyc %0d: load_ready=%b required %b", cyc, load_ready, exp_rdy);
            end
            if (load_ready === 1'b1) begin
                if (idx % 5 == 4 && idx / 5 < 256) sb.push_back(mk(8'(idx / 5), w));
                idx++;
            end
            phase = (phase == 5) ? 0 : phase + 1;
            cyc++;
            step();
        end
        n_checks++;
        if (idx != 257 * 5) begin n_fail++; $display("FAIL b2b_timeout: bytes sent=%0d required %0d", idx, 257 * 5); end
        load_en = 1'b0;
        load_valid = 1'b0;
        step();
        n_checks++;
        if (load_err !== 1'b1) begin n_fail++; $display("FAIL ovf_err: load_err=%b required 1", load_err); end
        n_checks++;
        if (core_hold !== 1'b0) begin n_fail++; $display("FAIL ovf_hold: core_hold=%b required 0", core_hold); end
        sb.push_back(mk(8'h37, word_of(8'h37)));
        sb.push_back(mk(8'hFF, word_of(255)));
        sb.push_back(mk(8'h00, word_of(0)));
        verify_sb();
    endtask

    task automatic test_reset_midload();
        load_en = 1'b1;
        step();
        send_word(40'h31_3233_3435); sb.push_back(mk(8'h00, 40'h31_3233_3435));
        send_word(40'h41_4243_4445); sb.push_back(mk(8'h01, 40'h41_4243_4445));
        send_byte(8'h51); send_byte(8'h52); send_byte(8'h53);
        sb.push_back(mk(8'h02, word_of(2)));
        reset = 1'b1;
        step();
        n_checks++;
        if (load_ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready: load_ready=%b required 0", load_ready); end
        n_checks++;
        if (pc !== 8'h00) begin n_fail++; $display("FAIL mid_pc: pc=%h required 00", pc); end
        n_checks++;
        if (core_hold !== 1'b1) begin n_fail++; $display("FAIL mid_hold: core_hold=%b required 1", core_hold); end
        n_checks++;
        if (load_words !== 8'h00) begin n_fail++; $display("FAIL mid_words: load_words=%h required 00", load_words); end
        load_en = 1'b0;
        step();
        reset = 1'b0;
        step();
        verify_sb();
    endtask

    initial begin
        test_reset();
        test_load_basic();
        test_partial();
        test_reset_preload();
        test_back_to_back();
        test_reset_midload();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fetch_unit
`default_nettype wire
